// File: rtl/lis_stream_bist.sv
// lis_stream_bist
//   Built-in self-test engine for the linear insertion sorter stream ports.
//   Each run sends FRAMES frames of LIS_SIZE pseudo-random elements (16-bit
//   Galois LFSR, taps 16'hB400, shift right) into the sorter. After each frame
//   it reads LIS_SIZE sorted elements back and checks their order and that
//   their sum matches the sum of the frame that was sent. The first error
//   (order, sum or idle timeout) ends the run.
//
// Ports
//   clock, reset         rising-edge clock, asynchronous active-high reset
//   start                one-cycle run request, honoured only in IDLE/DONE
//   mode_desc            0 = ascending expected, 1 = descending (latched on start)
//   seed[15:0]           LFSR seed, latched on start (0 maps to 16'hACE1)
//   in_valid/in_ready    input stream to the sorter, with in_data and in_last
//   out_valid/out_ready  output stream from the sorter, with out_data
//   busy, done, pass     run status; pass is meaningful while done=1
//   err_code[2:0]        0 none, 1 order, 2 sum, 3 timeout
//   out_count[15:0]      accepted output elements in the current/last run
//   dbg_state[1:0]       FSM state: 0 IDLE, 1 SEND, 2 RECV, 3 DONE
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both 1. in_valid is 1 for the whole of SEND and in_data/in_last only
// change after a transfer, so they stay stable while in_ready is low.
// out_ready is 1 for the whole of RECV.
module lis_stream_bist #(
  parameter int DATA_W   = 8,
  parameter int LIS_SIZE = 8,
  parameter int FRAMES   = 4,
  parameter int TIMEOUT  = 30000,
  parameter int SUM_W    = DATA_W + $clog2(LIS_SIZE) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              mode_desc,
  input  logic [15:0]       seed,
  input  logic              in_ready,
  output logic              in_valid,
  output logic [DATA_W-1:0] in_data,
  output logic              in_last,
  output logic              out_ready,
  input  logic              out_valid,
  input  logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [2:0]        err_code,
  output logic [15:0]       out_count,
  output logic [1:0]        dbg_state
);

  localparam int IDX_W  = $clog2(LIS_SIZE);
  localparam int FR_W   = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(LIS_SIZE - 1);
  localparam logic [FR_W-1:0]   LAST_FR  = FR_W'(FRAMES - 1);
  localparam logic [IDLE_W-1:0] TO_V     = IDLE_W'(TIMEOUT);

  localparam logic [2:0] ERR_ORDER   = 3'd1;
  localparam logic [2:0] ERR_SUM     = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_RECV = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic               mode_q, mode_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [FR_W-1:0]    frame_q, frame_d;
  logic [SUM_W-1:0]   in_sum_q, in_sum_d;
  logic [SUM_W-1:0]   out_sum_q, out_sum_d;
  logic [DATA_W-1:0]  prev_q, prev_d;
  logic [15:0]        out_count_q, out_count_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [2:0]         err_q, err_d;

  logic               in_hs, out_hs;
  logic [15:0]        lfsr_next;
  logic [SUM_W-1:0]   out_sum_next;
  logic [IDLE_W-1:0]  idle_next;
  logic               order_bad;

  // Stream outputs are pure functions of the state so reset clears them at once.
  assign in_valid  = (state_q == ST_SEND);
  assign out_ready = (state_q == ST_RECV);
  assign busy      = in_valid | out_ready;
  assign in_data   = in_valid ? lfsr_q[DATA_W-1:0] : '0;
  assign in_last   = in_valid && (idx_q == LAST_IDX);
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_code  = err_q;
  assign out_count = out_count_q;
  assign dbg_state = state_q;

  assign in_hs        = in_valid & in_ready;
  assign out_hs       = out_ready & out_valid;
  assign lfsr_next    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign out_sum_next = out_sum_q + SUM_W'(out_data);
  assign idle_next    = idle_q + IDLE_W'(1);
  // The first element of a frame has no predecessor to compare against.
  assign order_bad    = (idx_q != '0) &&
                        (mode_q ? (out_data > prev_q) : (out_data < prev_q));

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    mode_d      = mode_q;
    idx_d       = idx_q;
    frame_d     = frame_q;
    in_sum_d    = in_sum_q;
    out_sum_d   = out_sum_q;
    prev_d      = prev_q;
    out_count_d = out_count_q;
    idle_d      = idle_q;
    done_d      = done_q;
    pass_d      = pass_q;
    err_d       = err_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          lfsr_d      = (seed == 16'h0000) ? 16'hACE1 : seed;
          mode_d      = mode_desc;
          idx_d       = '0;
          frame_d     = '0;
          in_sum_d    = '0;
          out_sum_d   = '0;
          out_count_d = '0;
          idle_d      = '0;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          err_d       = '0;
          state_d     = ST_SEND;
        end
      end

      ST_SEND: begin
        if (in_hs) begin
          idle_d   = '0;
          in_sum_d = in_sum_q + SUM_W'(lfsr_q[DATA_W-1:0]);
          lfsr_d   = lfsr_next;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = ST_RECV;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else if (idle_next == TO_V) begin
          err_d   = ERR_TIMEOUT;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          idle_d = idle_next;
        end
      end

      ST_RECV: begin
        if (out_hs) begin
          idle_d      = '0;
          out_count_d = out_count_q + 16'd1;
          out_sum_d   = out_sum_next;
          prev_d      = out_data;
          if (order_bad) begin
            err_d   = ERR_ORDER;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (out_sum_next != in_sum_q) begin
              err_d   = ERR_SUM;
              done_d  = 1'b1;
              state_d = ST_DONE;
            end else begin
              in_sum_d  = '0;
              out_sum_d = '0;
              if (frame_q == LAST_FR) begin
                done_d  = 1'b1;
                pass_d  = 1'b1;
                state_d = ST_DONE;
              end else begin
                frame_d = frame_q + FR_W'(1);
                state_d = ST_SEND;
              end
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else if (idle_next == TO_V) begin
          err_d   = ERR_TIMEOUT;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          idle_d = idle_next;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      lfsr_q      <= '0;
      mode_q      <= 1'b0;
      idx_q       <= '0;
      frame_q     <= '0;
      in_sum_q    <= '0;
      out_sum_q   <= '0;
      prev_q      <= '0;
      out_count_q <= '0;
      idle_q      <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      mode_q      <= mode_d;
      idx_q       <= idx_d;
      frame_q     <= frame_d;
      in_sum_q    <= in_sum_d;
      out_sum_q   <= out_sum_d;
      prev_q      <= prev_d;
      out_count_q <= out_count_d;
      idle_q      <= idle_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_lis_stream_bist.sv
// Testbench for lis_stream_bist. A sorter model answers the BIST's input
// stream with sorted frames (optionally corrupted). Expected input elements
// and run results are computed from the seed by a reference model and queued;
// a monitor pops and compares them as the DUT presents them.
module tb_lis_stream_bist;
  localparam int DATA_W     = 8;
  localparam int LIS_SIZE   = 8;
  localparam int FRAMES     = 4;
  localparam int TB_TIMEOUT = 100;
  localparam int SUM_W      = DATA_W + $clog2(LIS_SIZE) + 1;

  logic              clock, reset, start, mode_desc;
  logic [15:0]       seed;
  logic              in_ready, in_valid, in_last;
  logic [DATA_W-1:0] in_data;
  logic              out_ready, out_valid;
  logic [DATA_W-1:0] out_data;
  logic              busy, done, pass;
  logic [2:0]        err_code;
  logic [15:0]       out_count;
  logic [1:0]        dbg_state;

  lis_stream_bist #(
    .DATA_W(DATA_W), .LIS_SIZE(LIS_SIZE), .FRAMES(FRAMES), .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .mode_desc(mode_desc), .seed(seed),
    .in_ready(in_ready), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .busy(busy), .done(done), .pass(pass), .err_code(err_code),
    .out_count(out_count), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard state ----------------
  logic [DATA_W:0] exp_q[$];   // {in_last, in_data} per expected input transfer
  logic [19:0]     res_q[$];   // {pass, err_code[2:0], out_count[15:0]}
  int checks = 0;
  int errors = 0;

  // sorter model configuration
  int fault      = 0;  // 0 none, 1 swap out 3/4 of frame 1, 2 last of frame 0 +1, 3 never valid
  bit model_desc = 0;
  bit slow_in    = 0;
  bit gappy_out  = 0;

  // monitor statistics
  int busy_cycles = 0;
  int recv_cycles = 0;
  int in_hs_cnt   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: expected input stream and run result, derived from the rules.
  task automatic push_expected(input logic [15:0] s, input bit desc, input int flt);
    logic [15:0] l;
    int vals[$];
    int insum, osum, cnt, err, tmp;
    bit fail;
    l = (s == 16'h0000) ? 16'hACE1 : s;
    cnt = 0; err = 0; fail = 0;
    for (int f = 0; f < FRAMES && !fail; f++) begin
      vals.delete();
      insum = 0;
      for (int i = 0; i < LIS_SIZE; i++) begin
        vals.push_back(int'(l) % (1 << DATA_W));
        exp_q.push_back({(i == LIS_SIZE - 1) ? 1'b1 : 1'b0, DATA_W'(l)});
        insum += vals[i];
        l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
      end
      if (flt == 3) begin
        fail = 1; err = 3;
      end else begin
        if (desc) vals.rsort(); else vals.sort();
        if (flt == 1 && f == 1) begin
          tmp = vals[3]; vals[3] = vals[4]; vals[4] = tmp;
        end
        if (flt == 2 && f == 0) vals[LIS_SIZE-1] = (vals[LIS_SIZE-1] + 1) % (1 << DATA_W);
        osum = 0;
        for (int i = 0; i < LIS_SIZE && !fail; i++) begin
          cnt++;
          osum += vals[i];
          if (i > 0 && (desc ? (vals[i] > vals[i-1]) : (vals[i] < vals[i-1]))) begin
            fail = 1; err = 1;
          end
        end
        if (!fail && (osum % (1 << SUM_W)) != (insum % (1 << SUM_W))) begin
          fail = 1; err = 2;
        end
      end
    end
    res_q.push_back({fail ? 1'b0 : 1'b1, 3'(err), 16'(cnt)});
  endtask

  // ---------------- sorter model / driver ----------------
  initial begin : sorter_model
    int in_buf[$];
    int out_q[$];
    int fr[$];
    int frame_idx;
    int cyc;
    int tmp;
    frame_idx = 0; cyc = 0;
    in_ready = 1'b0; out_valid = 1'b0; out_data = '0;
    forever begin
      @(negedge clock);
      cyc++;
      if (reset || (start && !busy)) begin
        in_buf.delete(); out_q.delete(); frame_idx = 0;
        in_ready = 1'b0; out_valid = 1'b0; out_data = '0;
      end else begin
        in_ready = slow_in ? (cyc % 3 == 0) : 1'b1;
        if (fault != 3 && out_q.size() > 0) begin
          out_valid = gappy_out ? ($urandom_range(0, 2) != 0) : 1'b1;
          out_data  = DATA_W'(out_q[0]);
        end else begin
          out_valid = 1'b0;
          out_data  = '0;
        end
        if (in_valid && in_ready) begin
          in_buf.push_back(int'(in_data));
          if (in_last) begin
            fr = in_buf;
            if (model_desc) fr.rsort(); else fr.sort();
            if (fault == 1 && frame_idx == 1) begin
              tmp = fr[3]; fr[3] = fr[4]; fr[4] = tmp;
            end
            if (fault == 2 && frame_idx == 0) fr[LIS_SIZE-1] = (fr[LIS_SIZE-1] + 1) % (1 << DATA_W);
            foreach (fr[i]) out_q.push_back(fr[i]);
            in_buf.delete();
            frame_idx++;
          end
        end
        if (out_valid && out_ready) void'(out_q.pop_front());
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [DATA_W:0]   e;
    logic [19:0]       r;
    bit                prev_stall, done_prev;
    logic [DATA_W-1:0] prev_data;
    logic              prev_last;
    prev_stall = 0; done_prev = 0; prev_data = '0; prev_last = 1'b0;
    forever begin
      @(negedge clock);
      #2;
      if (reset) begin
        prev_stall = 0;
        done_prev  = 0;
      end else begin
        if (busy) busy_cycles++;
        if (out_ready) recv_cycles++;
        if (in_valid) begin
          if (prev_stall) begin
            check("in_data_stall", in_data, prev_data);
            check("in_last_stall", in_last, prev_last);
          end
          if (in_ready) begin
            in_hs_cnt++;
            if (exp_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL in_extra actual=%0h expected=none at %0t", in_data, $time);
            end else begin
              e = exp_q.pop_front();
              check("in_data", in_data, e[DATA_W-1:0]);
              check("in_last", in_last, e[DATA_W]);
            end
          end
          prev_stall = !in_ready;
          prev_data  = in_data;
          prev_last  = in_last;
        end else begin
          prev_stall = 0;
        end
        if (done && !done_prev) begin
          if (res_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL done_unexpected actual=1 expected=0 at %0t", $time);
          end else begin
            r = res_q.pop_front();
            check("pass", pass, r[19]);
            check("err_code", err_code, r[18:16]);
            check("out_count", out_count, r[15:0]);
            check("busy_at_done", busy, 0);
          end
        end
        done_prev = done;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_run(input logic [15:0] s, input bit desc);
    push_expected(s, desc, fault);
    model_desc  = desc;
    busy_cycles = 0;
    recv_cycles = 0;
    in_hs_cnt   = 0;
    @(posedge clock); #1;
    seed = s; mode_desc = desc; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    seed = 16'($urandom);
    mode_desc = 1'($urandom);
    check("busy_after_start", busy, 1);
    check("in_valid_after_start", in_valid, 1);
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    @(negedge clock);
    while (!done && n < limit) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL done_wait actual=0 expected=1 after %0d cycles", limit);
    end
    @(negedge clock); #3;
  endtask

  task automatic end_test();
    repeat (4) @(negedge clock);
    #3;
    check("exp_q_drained", exp_q.size(), 0);
    check("res_q_drained", res_q.size(), 0);
    exp_q.delete();
    res_q.delete();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin : tests
    logic [15:0] s;
    int n;
    reset = 1'b1; start = 1'b0; mode_desc = 1'b0; seed = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_stream", {in_valid, in_data, in_last, out_ready}, 0);
    check("reset_status", {busy, done, pass, err_code, out_count, dbg_state}, 0);
    reset = 1'b0;

    // 1: ideal ascending sorter, fixed seed, no backpressure
    fault = 0; slow_in = 0; gappy_out = 0;
    start_run(16'hACE1, 1'b0);
    wait_done(2000);
    check("t1_run_length", busy_cycles, FRAMES * 2 * LIS_SIZE);
    check("t1_count", out_count, FRAMES * LIS_SIZE);
    end_test();

    // 2: order error (frame 1, elements 3/4 swapped)
    fault = 1;
    start_run(16'hACE1, 1'b0);
    wait_done(2000);
    end_test();

    // 3: sum error on frame 0, no further input
    fault = 2;
    start_run(16'hACE1, 1'b0);
    wait_done(2000);
    check("t3_no_in_valid", in_valid, 0);
    end_test();

    // 4: sorter never answers -> timeout after exactly TIMEOUT idle RECV cycles
    fault = 3;
    start_run(16'h1234, 1'b0);
    wait_done(2000);
    check("t4_idle_cycles", recv_cycles, TB_TIMEOUT);
    end_test();

    // 5: descending, input backpressure, output gaps, ignored mid-run start
    fault = 0; slow_in = 1; gappy_out = 1;
    for (int k = 0; k < 2; k++) begin
      s = 16'($urandom_range(1, 65535));
      start_run(s, 1'b1);
      repeat (10) @(posedge clock);
      #1;
      seed = 16'($urandom); start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      wait_done(5000);
      end_test();
    end
    // seed 0 maps to the default seed
    slow_in = 0; gappy_out = 0;
    start_run(16'h0000, 1'b0);
    wait_done(2000);
    end_test();

    // 6: reset in SEND after 5 inputs, then a clean rerun of the same seed
    s = 16'($urandom_range(1, 65535));
    start_run(s, 1'b0);
    n = 0;
    while (in_hs_cnt < 5 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("t6_reached_5", in_hs_cnt, 5);
    #1 reset = 1'b1;
    #1;
    check("t6_reset_stream", {in_valid, in_data, in_last, out_ready}, 0);
    check("t6_reset_status", {busy, done, pass, err_code, out_count}, 0);
    repeat (2) @(posedge clock);
    exp_q.delete();
    res_q.delete();
    #1 reset = 1'b0;
    start_run(s, 1'b0);
    wait_done(2000);
    check("t6_pass", pass, 1);
    end_test();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
